// File: rtl/dcm_prog_if.sv
// DCM_CLKGEN program-port sequencer bundle.
// Host/DCM side is master, sequencer is slave.
interface dcm_prog_if;
  logic       start;
  logic [7:0] m_minus1;
  logic [7:0] d_minus1;
  logic       progdone;
  logic       dcm_locked;
  logic       dcm_progdata;
  logic       dcm_progen;
  logic       pll_stop;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output start, m_minus1, d_minus1,
    output progdone, dcm_locked,
    input  dcm_progdata, dcm_progen,
    input  pll_stop, busy, done, error
  );

  modport slave (
    input  start, m_minus1, d_minus1,
    input  progdone, dcm_locked,
    output dcm_progdata, dcm_progen,
    output pll_stop, busy, done, error
  );
endinterface

// File: rtl/dcm_prog_ctrl.sv
// DCM_CLKGEN M/D reprogram sequencer (LoadD, LoadM, Go).
// Optional wait-state watchdog: DCM_PROG_TIMEOUT_EN.
module dcm_prog_ctrl #(
  parameter int unsigned LOCK_STABLE = 16,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic       clk,
  input  logic       reset,
  dcm_prog_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, LOAD_D, GAP1, LOAD_M, GAP2,
    GO, WAIT_DONE, WAIT_LOCK, DONE_S
  } state_t;

  localparam logic [7:0] LS = LOCK_STABLE[7:0];

  state_t     state;
  logic [7:0] m_q;
  logic [7:0] d_q;
  logic [3:0] bcnt;
  logic [7:0] lcnt;
  logic       progen_q;
  logic       progdata_q;
  logic       pll_stop_q;
  logic       busy_q;
  logic       done_q;
  logic       error_q;
  logic [9:0] seq;

`ifdef DCM_PROG_TIMEOUT_EN
  localparam logic [15:0] TO_M1 = 16'(TIMEOUT - 1);
  logic [15:0] wd;
`endif

  // Command word being shifted out: opcode bits then value, LSB first.
  always_comb begin
    seq = {d_q, 2'b01};
    if (state == LOAD_M) seq = {m_q, 2'b11};
  end

  // Sequencer with registered program-port and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      m_q        <= '0;
      d_q        <= '0;
      bcnt       <= '0;
      lcnt       <= '0;
      progen_q   <= 1'b0;
      progdata_q <= 1'b0;
      pll_stop_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef DCM_PROG_TIMEOUT_EN
      wd         <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            m_q <= bus.m_minus1;
            d_q <= bus.d_minus1;
            if (bus.m_minus1 == 8'd0) begin
              error_q <= 1'b1;
            end else begin
              error_q    <= 1'b0;
              pll_stop_q <= 1'b1;
              busy_q     <= 1'b1;
              progen_q   <= 1'b1;
              progdata_q <= 1'b1;
              bcnt       <= 4'd1;
              state      <= LOAD_D;
            end
          end
        end
        LOAD_D, LOAD_M: begin
          if (bcnt == 4'd10) begin
            progen_q   <= 1'b0;
            progdata_q <= 1'b0;
            state      <= (state == LOAD_D) ? GAP1 : GAP2;
          end else begin
            progdata_q <= seq[bcnt];
            bcnt       <= bcnt + 4'd1;
          end
        end
        GAP1: begin
          progen_q   <= 1'b1;
          progdata_q <= 1'b1;
          bcnt       <= 4'd1;
          state      <= LOAD_M;
        end
        GAP2: begin
          progen_q   <= 1'b1;
          progdata_q <= 1'b0;
          state      <= GO;
        end
        GO: begin
          progen_q <= 1'b0;
          state    <= WAIT_DONE;
`ifdef DCM_PROG_TIMEOUT_EN
          wd       <= '0;
`endif
        end
        WAIT_DONE: begin
          if (bus.progdone) begin
            lcnt  <= '0;
            state <= WAIT_LOCK;
`ifdef DCM_PROG_TIMEOUT_EN
            wd    <= '0;
          end else if (wd == TO_M1) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else begin
            wd <= wd + 16'd1;
`endif
          end
        end
        WAIT_LOCK: begin
          if (lcnt == LS) begin
            done_q <= 1'b1;
            state  <= DONE_S;
`ifdef DCM_PROG_TIMEOUT_EN
          end else if (wd == TO_M1) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
`endif
          end else begin
            lcnt <= bus.dcm_locked ? lcnt + 8'd1 : 8'd0;
`ifdef DCM_PROG_TIMEOUT_EN
            wd   <= wd + 16'd1;
`endif
          end
        end
        DONE_S: begin
          busy_q     <= 1'b0;
          pll_stop_q <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dcm_progen   = progen_q;
  assign bus.dcm_progdata = progdata_q;
  assign bus.pll_stop     = pll_stop_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Bench for dcm_prog_ctrl: directed scenarios plus
// randomized ratios/lock traces against a cycle model.
module tb_dcm_prog_ctrl;
  localparam int L = 16;
`ifdef DCM_PROG_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dcm_prog_if bus ();

  dcm_prog_ctrl #(
    .LOCK_STABLE(L),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  bit lk [0:199];
  int pd_c;
  int early_c;

  // {progen, progdata, busy, done, pll_stop, error}
  function automatic logic [5:0] obsv();
    return {bus.dcm_progen, bus.dcm_progdata, bus.busy,
            bus.done, bus.pll_stop, bus.error};
  endfunction

  task automatic chk(input string tag,
                     input logic [5:0] o,
                     input logic [5:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle c = values visible after the c-th edge past the start edge.
  task automatic run_op(input logic [7:0] m,
                        input logic [7:0] d,
                        input int bs_c,
                        input string tag);
    bit [9:0]   ds;
    bit [9:0]   ms;
    int         done_c;
    int         run;
    logic       pe;
    logic       pdv;
    logic [5:0] e;
    ds     = {d, 2'b01};
    ms     = {m, 2'b11};
    done_c = 0;
    run    = 0;
    for (int c = pd_c + 1; c < 200 && done_c == 0; c++) begin
      run = lk[c] ? run + 1 : 0;
      if (run == L) done_c = c + 2;
    end
    if (done_c == 0) done_c = 197;
    bus.start      = 1'b1;
    bus.m_minus1   = m;
    bus.d_minus1   = d;
    bus.progdone   = 1'b0;
    bus.dcm_locked = lk[0];
    tick();
    for (int c = 1; c <= done_c + 2; c++) begin
      bus.progdone   = (c == pd_c) || (c == early_c);
      bus.dcm_locked = lk[c];
      bus.start      = (c == bs_c);
      bus.m_minus1   = (c == bs_c) ? 8'd99 : 8'($urandom);
      bus.d_minus1   = 8'($urandom);
      pe  = 1'b0;
      pdv = 1'b0;
      if (c <= 10) begin
        pe  = 1'b1;
        pdv = ds[c-1];
      end else if (c >= 12 && c <= 21) begin
        pe  = 1'b1;
        pdv = ms[c-12];
      end else if (c == 23) begin
        pe = 1'b1;
      end
      e = {pe, pdv, 1'(c <= done_c), 1'(c == done_c),
           1'(c <= done_c), 1'b0};
      chk($sformatf("%s_c%0d", tag, c), obsv(), e);
      tick();
    end
    bus.start    = 1'b0;
    bus.progdone = 1'b0;
  endtask

  task automatic lock_from(input int t);
    for (int c = 0; c < 200; c++) lk[c] = (c >= t);
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.m_minus1   = '0;
    bus.d_minus1   = '0;
    bus.progdone   = 1'b0;
    bus.dcm_locked = 1'b0;
    #12;
    chk("reset", obsv(), 6'b000010);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Illegal ratio from reset: pll_stop stays 1.
    bus.start    = 1'b1;
    bus.m_minus1 = 8'd0;
    bus.d_minus1 = 8'd7;
    tick();
    bus.start = 1'b0;
    chk("illegal_rst", obsv(), 6'b000011);
    tick();
    chk("illegal_sticky", obsv(), 6'b000011);

    // Stream m=31 d=3 and completion at cycle 52.
    lock_from(35);
    pd_c    = 30;
    early_c = -1;
    run_op(8'd31, 8'd3, 0, "s2");

    // Illegal ratio after completion: pll_stop stays 0.
    bus.start    = 1'b1;
    bus.m_minus1 = 8'd0;
    tick();
    bus.start = 1'b0;
    chk("illegal_idle", obsv(), 6'b000001);

    // Legal start clears error; busy start in LOAD_M ignored.
    early_c = 8;
    run_op(8'd31, 8'd3, 15, "s3");

    // Lock glitch: 10 high, 1 low, then 16 high.
    lock_from(31);
    lk[41]  = 1'b0;
    early_c = -1;
    run_op(8'hA5, 8'h5A, 0, "s4");

    // Asynchronous reset inside LOAD_M.
    lock_from(35);
    pd_c         = 30;
    bus.start    = 1'b1;
    bus.m_minus1 = 8'd31;
    bus.d_minus1 = 8'd3;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("midrst", obsv(), 6'b000010);
    @(negedge clk);
    reset = 1'b0;
    tick();
    run_op(8'd31, 8'd3, 0, "s5");

    // Randomized ratios, progdone timing and lock traces.
    for (int t = 0; t < 6; t++) begin
      logic [7:0] m;
      logic [7:0] d;
      m       = 8'($urandom_range(1, 255));
      d       = 8'($urandom_range(0, 255));
      pd_c    = (t == 0) ? 24 : $urandom_range(24, 40);
      early_c = (t == 0) ? 23 : $urandom_range(2, 23);
      for (int c = 0; c < 200; c++)
        lk[c] = (c >= 100) ? 1'b1 : ($urandom_range(0, 15) != 0);
      run_op(m, d, $urandom_range(2, 30), $sformatf("rnd%0d", t));
    end

`ifdef DCM_PROG_TIMEOUT_EN
    // progdone never arrives: error 100 cycles after WAIT_DONE entry.
    bus.start      = 1'b1;
    bus.m_minus1   = 8'd31;
    bus.d_minus1   = 8'd3;
    bus.progdone   = 1'b0;
    bus.dcm_locked = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 123; c++) tick();
    chk("to_c123", obsv(), 6'b001010);
    tick();
    chk("to_c124", obsv(), 6'b000011);
    tick();
    chk("to_c125", obsv(), 6'b000011);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
